// File: rtl/hwpe_cmd_pkg.sv
// hwpe_cmd_pkg: shared constants, state encoding and the
// instruction-word builder for the HWPE command sequencer.
package hwpe_cmd_pkg;

   localparam logic [6:0]  OPCODE           = 7'b0001011;
   localparam logic [31:0] FMEM_ADDR2_START = 32'd16384;
   localparam int          NUM_ROWS         = 8;
   localparam int          NUM_PE           = 16;

   localparam logic [6:0] F7_RESET  = 7'd64;
   localparam logic [6:0] F7_WCFG   = 7'd2;
   localparam logic [6:0] F7_WFAD   = 7'd1;
   localparam logic [6:0] F7_WACC   = 7'd8;
   localparam logic [6:0] F7_MATRIX = 7'd4;
   localparam logic [6:0] F7_RACC   = 7'd16;
   localparam logic [6:0] F7_RELU   = 7'd32;

   // {xd, xs1, xs2}
   localparam logic [2:0] XS_NONE = 3'b000;
   localparam logic [2:0] XS_RS12 = 3'b011;
   localparam logic [2:0] XS_RS1  = 3'b010;
   localparam logic [2:0] XS_RD   = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RST,
      S_WCFG,
      S_WFAD,
      S_WACC,
      S_MATRIX,
      S_DRAIN
   } state_t;

   function automatic logic [31:0] build_instr(
      input logic [6:0] funct7,
      input logic [4:0] rs2f,
      input logic [4:0] rs1f,
      input logic [2:0] xs,
      input logic [4:0] rd
   );
      return {funct7, rs2f, rs1f, xs, rd, OPCODE};
   endfunction

endpackage

// File: rtl/hwpe_tile_cnt.sv
// hwpe_tile_cnt: k/w/h tile loop with row/pe inner counters.
// Ports: clr/adv control, counts in; row, pe, tile_last, all_last out.
module hwpe_tile_cnt
   import hwpe_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        adv,
   input  logic        relu_mode,
   input  logic [9:0]  k_count,
   input  logic [15:0] w_count,
   input  logic [15:0] h_count,
   output logic [2:0]  row,
   output logic [3:0]  pe,
   output logic        tile_last,
   output logic        all_last
);

   logic [9:0]  k_q;
   logic [15:0] w_q;
   logic [15:0] h_q;
   logic        k_end;
   logic        w_end;
   logic        h_end;

   assign k_end = (k_q == k_count - 10'd1);
   assign w_end = (w_q == w_count - 16'd1);
   assign h_end = (h_q == h_count - 16'd1);

   // relu drain walks rows only; racc walks every pe of every row
   assign tile_last = (row == 3'(NUM_ROWS - 1)) &&
                      (relu_mode || pe == 4'(NUM_PE - 1));
   assign all_last  = tile_last && k_end && w_end && h_end;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         k_q <= '0;
         w_q <= '0;
         h_q <= '0;
         row <= '0;
         pe  <= '0;
      end else if (adv) begin
         if (!tile_last) begin
            if (relu_mode) row <= row + 3'd1;
            else {row, pe} <= {row, pe} + 7'd1;
         end else begin
            row <= '0;
            pe  <= '0;
            if (!h_end) begin
               h_q <= h_q + 16'd1;
            end else begin
               h_q <= '0;
               if (!w_end) begin
                  w_q <= w_q + 16'd1;
               end else begin
                  w_q <= '0;
                  k_q <= k_q + 10'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/hwpe_cmd_seq.sv
// hwpe_cmd_seq: emits the full conv-layer command stream to the HWPE.
// Ports: start + cfg_* in; cmd_valid/ready, cmd_instr/rs1/rs2; busy, done.
module hwpe_cmd_seq
   import hwpe_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  cfg_kernel_size,
   input  logic [1:0]  cfg_data_type,
   input  logic        cfg_layer_type,
   input  logic        cfg_kernel_333,
   input  logic [15:0] cfg_h_count,
   input  logic [15:0] cfg_w_count,
   input  logic [9:0]  cfg_k_count,
   input  logic [15:0] cfg_h_stride,
   input  logic [15:0] cfg_w_stride,
   input  logic [15:0] cfg_ch_count,
   input  logic [15:0] cfg_w_offset,
   input  logic [4:0]  cfg_acc_shift,
   input  logic        cfg_relu_mode,
   input  logic [31:0] cfg_relu_addr,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_instr,
   output logic [31:0] cmd_rs1,
   output logic [31:0] cmd_rs2,
   output logic        busy,
   output logic        done
);

   state_t      state;
   state_t      state_nx;

   logic [3:0]  ks_q;
   logic [1:0]  dt_q;
   logic        lt_q;
   logic        k333_q;
   logic [15:0] hc_q;
   logic [15:0] wc_q;
   logic [9:0]  kc_q;
   logic [15:0] hstr_q;
   logic [15:0] wstr_q;
   logic [15:0] ch_q;
   logic [15:0] woff_q;
   logic [4:0]  sh_q;
   logic        relu_q;
   logic [31:0] raddr_q;
   logic [31:0] hs_q;
   logic [6:0]  sub_q;
   logic        done_q;
   logic        done_nx;

   logic        fire;
   logic        zero_cnt;
   logic [31:0] wf_off;
   logic        wf_zero;
   logic [2:0]  t_row;
   logic [3:0]  t_pe;
   logic        t_last;
   logic        t_all;
   logic [4:0]  row_f;

   assign cmd_valid = (state != S_IDLE) && (state != S_PREP);
   assign fire      = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE);
   assign done      = done_q;
   assign zero_cnt  = (kc_q == '0) || (wc_q == '0) || (hc_q == '0);

   // WFAD pair i uses i*hs; upper two pairs vanish in 3x3x3 mode
   always_comb begin
      unique case (sub_q[1:0])
         2'd0:    wf_off = '0;
         2'd1:    wf_off = hs_q;
         2'd2:    wf_off = hs_q << 1;
         default: wf_off = (hs_q << 1) + hs_q;
      endcase
   end
   assign wf_zero = k333_q && sub_q[1];

   // tile-end marker on every tile but the last
   assign row_f = {t_last && !t_all, 1'b0, t_row};

   hwpe_tile_cnt u_tile (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != S_DRAIN),
      .adv       (fire && state == S_DRAIN),
      .relu_mode (relu_q),
      .k_count   (kc_q),
      .w_count   (wc_q),
      .h_count   (hc_q),
      .row       (t_row),
      .pe        (t_pe),
      .tile_last (t_last),
      .all_last  (t_all)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ks_q    <= '0;
         dt_q    <= '0;
         lt_q    <= 1'b0;
         k333_q  <= 1'b0;
         hc_q    <= '0;
         wc_q    <= '0;
         kc_q    <= '0;
         hstr_q  <= '0;
         wstr_q  <= '0;
         ch_q    <= '0;
         woff_q  <= '0;
         sh_q    <= '0;
         relu_q  <= 1'b0;
         raddr_q <= '0;
         hs_q    <= '0;
         sub_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= done_nx;
         if (state == S_IDLE && start) begin
            ks_q    <= cfg_kernel_size;
            dt_q    <= cfg_data_type;
            lt_q    <= cfg_layer_type;
            k333_q  <= cfg_kernel_333;
            hc_q    <= cfg_h_count;
            wc_q    <= cfg_w_count;
            kc_q    <= cfg_k_count;
            hstr_q  <= cfg_h_stride;
            wstr_q  <= cfg_w_stride;
            ch_q    <= cfg_ch_count;
            woff_q  <= cfg_w_offset;
            sh_q    <= cfg_acc_shift;
            relu_q  <= cfg_relu_mode;
            raddr_q <= cfg_relu_addr;
         end
         if (state == S_PREP) begin
            hs_q  <= 32'(hc_q) * 32'(hstr_q);
            sub_q <= '0;
         end else if (fire && state == S_WFAD) begin
            sub_q <= (sub_q[1:0] == 2'd3) ? '0 : sub_q + 7'd1;
         end else if (fire && state == S_WACC) begin
            sub_q <= sub_q + 7'd1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      done_nx   = 1'b0;
      cmd_instr = '0;
      cmd_rs1   = '0;
      cmd_rs2   = '0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nx = S_PREP;
         end
         S_PREP: begin
            state_nx = S_RST;
         end
         S_RST: begin
            cmd_instr = build_instr(F7_RESET, 5'd0, 5'd0, XS_NONE, 5'd0);
            if (fire) state_nx = S_WCFG;
         end
         S_WCFG: begin
            cmd_instr = build_instr(F7_WCFG, 5'd0, 5'd0, XS_RS12, 5'd0);
            cmd_rs1   = {woff_q, ch_q};
            cmd_rs2   = {9'b0, kc_q, sh_q, k333_q, lt_q, dt_q, ks_q};
            if (fire) state_nx = S_WFAD;
         end
         S_WFAD: begin
            cmd_instr = build_instr(F7_WFAD, 5'd0, 5'd0, XS_RS12,
                                    {2'b0, sub_q[1:0], 1'b0});
            cmd_rs1   = wf_zero ? '0 : wf_off;
            cmd_rs2   = wf_zero ? '0 : FMEM_ADDR2_START + wf_off;
            if (fire && sub_q[1:0] == 2'd3) state_nx = S_WACC;
         end
         S_WACC: begin
            cmd_instr = build_instr(F7_WACC, {1'b0, sub_q[3:0]}, 5'd0,
                                    XS_RS1, {2'b0, sub_q[6:4]});
            if (fire && sub_q == 7'd127) state_nx = S_MATRIX;
         end
         S_MATRIX: begin
            cmd_instr = build_instr(F7_MATRIX, 5'd0, 5'd0, XS_RS12, 5'd0);
            cmd_rs1   = {wc_q, hc_q};
            cmd_rs2   = {wstr_q, hstr_q};
            if (fire) begin
               state_nx = zero_cnt ? S_IDLE : S_DRAIN;
               done_nx  = zero_cnt;
            end
         end
         S_DRAIN: begin
            if (relu_q) begin
               cmd_instr = build_instr(F7_RELU, row_f, 5'd0, XS_RS1, 5'd0);
               cmd_rs1   = raddr_q;
            end else begin
               cmd_instr = build_instr(F7_RACC, {1'b0, t_pe}, row_f,
                                       XS_RD, 5'd0);
            end
            if (fire && t_all) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hwpe_cmd_seq.sv
// tb_hwpe_cmd_seq: directed bench for the HWPE command sequencer.
// Drives layer configs, captures each handshake and checks the stream.
module tb_hwpe_cmd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  cfg_kernel_size;
   logic [1:0]  cfg_data_type;
   logic        cfg_layer_type;
   logic        cfg_kernel_333;
   logic [15:0] cfg_h_count;
   logic [15:0] cfg_w_count;
   logic [9:0]  cfg_k_count;
   logic [15:0] cfg_h_stride;
   logic [15:0] cfg_w_stride;
   logic [15:0] cfg_ch_count;
   logic [15:0] cfg_w_offset;
   logic [4:0]  cfg_acc_shift;
   logic        cfg_relu_mode;
   logic [31:0] cfg_relu_addr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_instr;
   logic [31:0] cmd_rs1;
   logic [31:0] cmd_rs2;
   logic        busy;
   logic        done;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] gi[$];
   logic [31:0] g1[$];
   logic [31:0] g2[$];
   logic [31:0] ei[$];
   logic [31:0] e1[$];
   logic [31:0] e2[$];
   int          n_done;
   bit          stab_bad;
   bit          busy_at_done;
   bit          timed_out;

   always #5 clk = ~clk;

   hwpe_cmd_seq dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_data_type   (cfg_data_type),
      .cfg_layer_type  (cfg_layer_type),
      .cfg_kernel_333  (cfg_kernel_333),
      .cfg_h_count     (cfg_h_count),
      .cfg_w_count     (cfg_w_count),
      .cfg_k_count     (cfg_k_count),
      .cfg_h_stride    (cfg_h_stride),
      .cfg_w_stride    (cfg_w_stride),
      .cfg_ch_count    (cfg_ch_count),
      .cfg_w_offset    (cfg_w_offset),
      .cfg_acc_shift   (cfg_acc_shift),
      .cfg_relu_mode   (cfg_relu_mode),
      .cfg_relu_addr   (cfg_relu_addr),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_instr       (cmd_instr),
      .cmd_rs1         (cmd_rs1),
      .cmd_rs2         (cmd_rs2),
      .busy            (busy),
      .done            (done)
   );

   function automatic logic [31:0] mk(input int f7, input int rs2f,
                                      input int rs1f, input int xs,
                                      input int rd);
      return {f7[6:0], rs2f[4:0], rs1f[4:0], xs[2:0], rd[4:0], 7'h0B};
   endfunction

   function automatic logic [31:0] at(input int i);
      return (i < gi.size()) ? gi[i] : 32'hDEAD_BEEF;
   endfunction

   // index of the first differing command, size mismatch included
   function automatic int first_diff();
      int n = (gi.size() > ei.size()) ? gi.size() : ei.size();
      for (int i = 0; i < n; i++) begin
         if (i >= gi.size() || i >= ei.size()) return i;
         if (gi[i] !== ei[i] || g1[i] !== e1[i] || g2[i] !== e2[i])
            return i;
      end
      return -1;
   endfunction

   task automatic push_exp(input logic [31:0] i, input logic [31:0] a,
                           input logic [31:0] b);
      ei.push_back(i);
      e1.push_back(a);
      e2.push_back(b);
   endtask

   task automatic set_cfg(input int k, input int w, input int h,
                          input bit relu, input bit k333);
      cfg_kernel_size = 4'd3;
      cfg_data_type   = 2'd1;
      cfg_layer_type  = 1'b0;
      cfg_kernel_333  = k333;
      cfg_h_count     = 16'(h);
      cfg_w_count     = 16'(w);
      cfg_k_count     = 10'(k);
      cfg_h_stride    = 16'd6;
      cfg_w_stride    = 16'd40;
      cfg_ch_count    = 16'd32;
      cfg_w_offset    = 16'd3;
      cfg_acc_shift   = 5'd9;
      cfg_relu_mode   = relu;
      cfg_relu_addr   = 32'd128;
   endtask

   // reference stream built from the current cfg_* values
   task automatic gen_exp();
      logic [31:0] hs;
      logic [31:0] off;
      int          tiles;
      int          per;
      int          row;
      int          rf;
      ei.delete(); e1.delete(); e2.delete();
      hs = 32'(cfg_h_count) * 32'(cfg_h_stride);
      push_exp(mk(64, 0, 0, 0, 0), 0, 0);
      push_exp(mk(2, 0, 0, 3, 0), {cfg_w_offset, cfg_ch_count},
               {9'b0, cfg_k_count, cfg_acc_shift, cfg_kernel_333,
                cfg_layer_type, cfg_data_type, cfg_kernel_size});
      for (int i = 0; i < 4; i++) begin
         off = 32'(i) * hs;
         if (cfg_kernel_333 && i >= 2)
            push_exp(mk(1, 0, 0, 3, 2 * i), 0, 0);
         else
            push_exp(mk(1, 0, 0, 3, 2 * i), off, 32'd16384 + off);
      end
      for (int r = 0; r < 8; r++)
         for (int p = 0; p < 16; p++)
            push_exp(mk(8, p, 0, 2, r), 0, 0);
      push_exp(mk(4, 0, 0, 3, 0), {cfg_w_count, cfg_h_count},
               {cfg_w_stride, cfg_h_stride});
      tiles = int'(cfg_k_count) * int'(cfg_w_count) * int'(cfg_h_count);
      per   = cfg_relu_mode ? 8 : 128;
      for (int t = 0; t < tiles; t++) begin
         for (int j = 0; j < per; j++) begin
            row = cfg_relu_mode ? j : j / 16;
            rf  = (j == per - 1 && t != tiles - 1) ? 16 + row : row;
            if (cfg_relu_mode)
               push_exp(mk(32, rf, 0, 2, 0), cfg_relu_addr, 0);
            else
               push_exp(mk(16, j % 16, rf, 4, 0), 0, 0);
         end
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // capture handshakes until done; stall_pct of cycles drop ready
   task automatic run(input int stall_pct, input bit poke, input int max_cyc);
      logic [31:0] pi;
      logic [31:0] p1;
      logic [31:0] p2;
      bit          hold;
      gi.delete(); g1.delete(); g2.delete();
      n_done = 0; stab_bad = 0; timed_out = 1; busy_at_done = 1;
      hold = 0; pi = '0; p1 = '0; p2 = '0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (hold && (!cmd_valid || cmd_instr !== pi ||
                      cmd_rs1 !== p1 || cmd_rs2 !== p2))
            stab_bad = 1;
         if (done) begin
            n_done++;
            busy_at_done = busy;
            timed_out = 0;
            break;
         end
         cmd_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
         if (poke) start = (c % 37 == 5);
         if (cmd_valid && cmd_ready) begin
            gi.push_back(cmd_instr);
            g1.push_back(cmd_rs1);
            g2.push_back(cmd_rs2);
         end
         hold = cmd_valid && !cmd_ready;
         pi = cmd_instr; p1 = cmd_rs1; p2 = cmd_rs2;
      end
      start = 1'b0;
      cmd_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) n_done++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; cmd_ready = 1'b0;
      set_cfg(1, 1, 1, 0, 0);
      repeat (3) @(negedge clk);
      n_assert++;
      if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b want 0", cmd_valid);
      end
      n_assert++;
      if ({cmd_instr, cmd_rs1, cmd_rs2} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_payload: got %h %h %h want 0 0 0",
                  cmd_instr, cmd_rs1, cmd_rs2);
      end
      n_assert++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: busy %b done %b want 0 0",
                            busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
      n_assert++;
      if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: valid %b busy %b want 0 0",
                            cmd_valid, busy);
      end
   endtask

   task automatic test_racc_baseline();
      int d;
      set_cfg(1, 1, 1, 0, 0);
      gen_exp();
      do_start();
      n_assert++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_after_start: got %b want 1", busy);
      end
      run(0, 0, 2000);
      n_assert++;
      if (timed_out) begin
         n_fail++; $display("FAIL base_timeout: got no done want done");
      end
      n_assert++;
      if (gi.size() != 263) begin
         n_fail++; $display("FAIL base_count: got %0d want 263", gi.size());
      end
      d = first_diff();
      n_assert++;
      if (d >= 0) begin
         n_fail++; $display("FAIL base_stream: first diff at %0d got %h want %h",
                            d, at(d), (d < ei.size()) ? ei[d] : 32'h0);
      end
      n_assert++;
      if (at(0) !== 32'h8000000B || at(1) !== 32'h0400300B ||
          at(2) !== 32'h0200300B || at(3) !== 32'h0200310B) begin
         n_fail++;
         $display("FAIL base_head: got %h %h %h %h want 8000000b 0400300b 0200300b 0200310b",
                  at(0), at(1), at(2), at(3));
      end
      n_assert++;
      if (at(262) !== 32'h20F3C00B) begin
         n_fail++; $display("FAIL base_last: got %h want 20f3c00b", at(262));
      end
      n_assert++;
      if (n_done != 1) begin
         n_fail++; $display("FAIL base_done_pulses: got %0d want 1", n_done);
      end
      n_assert++;
      if (busy_at_done !== 1'b0) begin
         n_fail++; $display("FAIL base_busy_at_done: got %b want 0",
                            busy_at_done);
      end
   endtask

   task automatic test_relu();
      int d;
      int bad;
      set_cfg(1, 1, 2, 1, 0);
      gen_exp();
      do_start();
      run(0, 0, 2000);
      n_assert++;
      if (timed_out || gi.size() != 151) begin
         n_fail++; $display("FAIL relu_count: got %0d want 151 (timeout %b)",
                            gi.size(), timed_out);
      end
      d = first_diff();
      n_assert++;
      if (d >= 0) begin
         n_fail++; $display("FAIL relu_stream: first diff at %0d got %h",
                            d, at(d));
      end
      n_assert++;
      if (at(142) !== 32'h4170200B) begin
         n_fail++; $display("FAIL relu_marker: got %h want 4170200b", at(142));
      end
      n_assert++;
      if (at(150) !== 32'h4070200B) begin
         n_fail++; $display("FAIL relu_last: got %h want 4070200b", at(150));
      end
      bad = 0;
      for (int i = 135; i < g1.size(); i++)
         if (g1[i] !== 32'd128) bad++;
      n_assert++;
      if (bad != 0 || g1.size() < 136) begin
         n_fail++; $display("FAIL relu_addr: got %0d bad rs1 want 0", bad);
      end
      n_assert++;
      if (n_done != 1) begin
         n_fail++; $display("FAIL relu_done_pulses: got %0d want 1", n_done);
      end
   endtask

   task automatic test_tile_marker();
      int d;
      set_cfg(1, 1, 2, 0, 0);
      gen_exp();
      do_start();
      run(0, 0, 2000);
      n_assert++;
      if (timed_out || gi.size() != 391) begin
         n_fail++; $display("FAIL marker_count: got %0d want 391", gi.size());
      end
      n_assert++;
      if (at(262) !== 32'h20FBC00B) begin
         n_fail++; $display("FAIL marker_tile_end: got %h want 20fbc00b",
                            at(262));
      end
      n_assert++;
      if (at(263) !== 32'h2000400B || at(390) !== 32'h20F3C00B) begin
         n_fail++; $display("FAIL marker_next: got %h %h want 2000400b 20f3c00b",
                            at(263), at(390));
      end
      d = first_diff();
      n_assert++;
      if (d >= 0) begin
         n_fail++; $display("FAIL marker_stream: first diff at %0d got %h",
                            d, at(d));
      end
   endtask

   task automatic test_base_addr();
      logic [31:0] x1[4];
      logic [31:0] x2[4];
      x1 = '{32'd0, 32'd12, 32'd0, 32'd0};
      x2 = '{32'd16384, 32'd16396, 32'd0, 32'd0};
      set_cfg(1, 1, 2, 1, 1);
      do_start();
      run(0, 0, 2000);
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (g1.size() < 6 || g1[2 + i] !== x1[i] || g2[2 + i] !== x2[i]) begin
            n_fail++;
            $display("FAIL base333_pair%0d: got %0d,%0d want %0d,%0d", i,
                     (g1.size() > 5) ? g1[2 + i] : 32'h0,
                     (g2.size() > 5) ? g2[2 + i] : 32'h0, x1[i], x2[i]);
         end
      end
      x1 = '{32'd0, 32'd12, 32'd24, 32'd36};
      x2 = '{32'd16384, 32'd16396, 32'd16408, 32'd16420};
      set_cfg(1, 1, 2, 1, 0);
      do_start();
      run(0, 0, 2000);
      for (int i = 2; i < 4; i++) begin
         n_assert++;
         if (g1.size() < 6 || g1[2 + i] !== x1[i] || g2[2 + i] !== x2[i]) begin
            n_fail++;
            $display("FAIL base_pair%0d: got %0d,%0d want %0d,%0d", i,
                     (g1.size() > 5) ? g1[2 + i] : 32'h0,
                     (g2.size() > 5) ? g2[2 + i] : 32'h0, x1[i], x2[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int d;
      set_cfg(2, 1, 1, 0, 0);
      gen_exp();
      do_start();
      run(30, 1, 4000);
      n_assert++;
      if (timed_out) begin
         n_fail++; $display("FAIL bp_timeout: got no done want done");
      end
      d = first_diff();
      n_assert++;
      if (d >= 0) begin
         n_fail++; $display("FAIL bp_stream: first diff at %0d got %h (n %0d)",
                            d, at(d), gi.size());
      end
      n_assert++;
      if (stab_bad) begin
         n_fail++; $display("FAIL bp_stable: got payload change want stable");
      end
      n_assert++;
      if (n_done != 1) begin
         n_fail++; $display("FAIL bp_done_pulses: got %0d want 1", n_done);
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      int d;
      bit hit;
      set_cfg(1, 1, 1, 0, 0);
      do_start();
      cmd_ready = 1'b1;
      cnt = 0;
      hit = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (cmd_valid && cmd_ready) begin
            if (cnt == 140) begin
               rst = 1'b1;
               hit = 1;
               break;
            end
            cnt++;
         end
      end
      n_assert++;
      if (!hit) begin
         n_fail++; $display("FAIL rstmid_reach: got %0d cmds want 140", cnt);
      end
      @(negedge clk);
      n_assert++;
      if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_valid: valid %b busy %b want 0 0",
                            cmd_valid, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      n_assert++;
      if (cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_idle: got %b want 0", cmd_valid);
      end
      gen_exp();
      do_start();
      run(0, 0, 2000);
      d = first_diff();
      n_assert++;
      if (d >= 0 || at(0) !== 32'h8000000B) begin
         n_fail++; $display("FAIL rstmid_replay: diff at %0d first %h want 8000000b",
                            d, at(0));
      end
   endtask

   task automatic test_zero_count();
      int d;
      set_cfg(1, 1, 0, 0, 0);
      gen_exp();
      do_start();
      run(0, 0, 1000);
      n_assert++;
      if (timed_out || gi.size() != 135) begin
         n_fail++; $display("FAIL zero_count: got %0d want 135 (timeout %b)",
                            gi.size(), timed_out);
      end
      d = first_diff();
      n_assert++;
      if (d >= 0) begin
         n_fail++; $display("FAIL zero_stream: first diff at %0d got %h",
                            d, at(d));
      end
      n_assert++;
      if (n_done != 1) begin
         n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", n_done);
      end
   endtask

   initial begin
      test_reset();
      test_racc_baseline();
      test_relu();
      test_tile_marker();
      test_base_addr();
      test_backpressure();
      test_reset_mid();
      test_zero_count();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
